// File: rtl/twos_comp_seq.sv
// twos_comp_seq: multi-cycle two's-complement unit (pass / negate / abs /
// conditional negate) for the floating-point adder datapath. The operand is
// processed CHUNK bits per cycle through one narrow incrementer with a
// registered carry between chunks.
//
// Optional feature: define TWOS_COMP_SAT_EN to saturate the negated
// most-negative operand to the max positive value instead of wrapping.
module twos_comp_seq #(
  parameter int WIDTH = 25,
  parameter int CHUNK = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [1:0]       in_mode,
  input  logic             in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  // Operand padded to a whole number of chunks so the last partial chunk
  // can be sliced like any other; padding bits never reach out_s.
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PAD_W-1:0] CHUNK_MASK = PAD_W'({CHUNK{1'b1}});
`ifdef TWOS_COMP_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS    = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               inv_q, inv_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [CHUNK-1:0]   chunk;
  logic [CHUNK:0]     sum;
  int                 sh;

  // State register and datapath flops; reset discards any in-flight operand.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its *_d input, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      inv_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      inv_q   <= inv_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic: accept in IDLE, one chunk per RUN cycle, hold in DONE.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    inv_d   = inv_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    sh      = int'(idx_q) * CHUNK;
    chunk   = '0;
    sum     = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          inv_d   = (in_mode == 2'b01)
                  | ((in_mode == 2'b10) & in_a[WIDTH-1])
                  | ((in_mode == 2'b11) & in_neg);
          carry_d = inv_d;
          idx_d   = '0;
          ovf_d   = inv_d & (in_a == MOST_NEG);
          state_d = RUN;
        end
      end

      RUN: begin
        chunk   = CHUNK'(PAD_W'(a_q) >> sh);
        sum     = {1'b0, (inv_q ? ~chunk : chunk)} + {{CHUNK{1'b0}}, carry_q};
        carry_d = sum[CHUNK];
        // Merge this chunk into the result; bits past WIDTH are dropped.
        s_d     = WIDTH'((PAD_W'(s_q) & ~(CHUNK_MASK << sh))
                       | (PAD_W'(sum[CHUNK-1:0]) << sh));
        if (idx_q == LAST_IDX) begin
`ifdef TWOS_COMP_SAT_EN
          if (ovf_q) s_d = MAX_POS;
`endif
          zero_d  = (s_d == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state; result and flags come from flops.
  always_comb begin
    in_ready  = (state_q == IDLE) & ~rst;
    out_valid = (state_q == DONE);
    out_s     = s_q;
    out_ovf   = ovf_q;
    out_zero  = zero_q;
  end

endmodule

// File: tb/tb_twos_comp_seq.sv
// Directed testbench for twos_comp_seq: three instances (CHUNK 5, 7, 1) at
// WIDTH 25, driven on the falling edge and sampled on the falling edge.
module tb_twos_comp_seq;

  localparam int W = 25;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_a;
  logic [1:0]   in_mode;
  logic         in_neg;
  logic         out_ready;
  logic         iv5, iv7, iv1;
  logic         ir5, ir7, ir1;
  logic         ov5, ov7, ov1;
  logic         of5, of7, of1;
  logic         z5, z7, z1;
  logic [W-1:0] s5, s7, s1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  twos_comp_seq #(.WIDTH(W), .CHUNK(5)) u_c5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_a(in_a),
    .in_mode(in_mode), .in_neg(in_neg), .out_valid(ov5), .out_ready(out_ready),
    .out_s(s5), .out_ovf(of5), .out_zero(z5));

  twos_comp_seq #(.WIDTH(W), .CHUNK(7)) u_c7 (
    .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7), .in_a(in_a),
    .in_mode(in_mode), .in_neg(in_neg), .out_valid(ov7), .out_ready(out_ready),
    .out_s(s7), .out_ovf(of7), .out_zero(z7));

  twos_comp_seq #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(in_a),
    .in_mode(in_mode), .in_neg(in_neg), .out_valid(ov1), .out_ready(out_ready),
    .out_s(s1), .out_ovf(of1), .out_zero(z1));

  // Selected instance view for the shared operation driver.
  int           cur_sel = 0;
  logic         cur_valid, cur_ovf, cur_zero;
  logic [W-1:0] cur_s;

  always_comb begin
    cur_valid = ov5; cur_s = s5; cur_ovf = of5; cur_zero = z5;
    if (cur_sel == 1) begin
      cur_valid = ov7; cur_s = s7; cur_ovf = of7; cur_zero = z7;
    end else if (cur_sel == 2) begin
      cur_valid = ov1; cur_s = s1; cur_ovf = of1; cur_zero = z1;
    end
  end

  task automatic set_iv(input int sel, input logic v);
    iv5 = (sel == 0) ? v : 1'b0;
    iv7 = (sel == 1) ? v : 1'b0;
    iv1 = (sel == 2) ? v : 1'b0;
  endtask

  // Drive one operand, scramble the inputs during RUN, wait (bounded) for
  // out_valid and report the result plus cycles from the accepting edge.
  task automatic do_op(input int sel, input logic [W-1:0] a, input logic [1:0] mode,
                       input logic neg, output logic [W-1:0] s, output logic ovf,
                       output logic zero, output int lat);
    cur_sel = sel;
    @(negedge clk);
    in_a = a; in_mode = mode; in_neg = neg; set_iv(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_iv(sel, 1'b0);
    in_a = ~a; in_mode = ~mode; in_neg = ~neg;
    lat = 0;
    while (!cur_valid && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    s = cur_s; ovf = cur_ovf; zero = cur_zero;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; set_iv(0, 1'b0); out_ready = 1'b1;
    in_a = '0; in_mode = 2'b00; in_neg = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ov5 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov5); end
    n_checks++; if (s5 !== '0) begin n_fail++; $display("FAIL reset_out_s: got %h want 0", s5); end
    n_checks++; if (of5 !== 1'b0 || z5 !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b zero=%b want 0 0", of5, z5); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({ir5, ir7, ir1} !== 3'b111) begin n_fail++; $display("FAIL reset_in_ready: got %b want 111", {ir5, ir7, ir1}); end
  endtask

  task automatic test_negate();
    logic [W-1:0] s; logic ovf, zero; int lat;
    do_op(0, 25'h0000001, 2'b01, 1'b0, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h1FFFFFF) begin n_fail++; $display("FAIL neg1_s: got %h want 1ffffff", s); end
    n_checks++; if (ovf !== 1'b0 || zero !== 1'b0) begin n_fail++; $display("FAIL neg1_flags: got ovf=%b zero=%b want 0 0", ovf, zero); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL neg1_latency: got %0d want 5", lat); end
    do_op(0, 25'h0000000, 2'b01, 1'b0, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h0) begin n_fail++; $display("FAIL neg0_s: got %h want 0", s); end
    n_checks++; if (ovf !== 1'b0 || zero !== 1'b1) begin n_fail++; $display("FAIL neg0_flags: got ovf=%b zero=%b want 0 1", ovf, zero); end
  endtask

  task automatic test_pass();
    logic [W-1:0] s; logic ovf, zero; int lat;
    do_op(0, 25'h0ABCDEF, 2'b00, 1'b1, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h0ABCDEF || zero !== 1'b0) begin n_fail++; $display("FAIL pass_s: got %h zero=%b want 0abcdef 0", s, zero); end
    do_op(0, 25'h0000003, 2'b11, 1'b0, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h0000003) begin n_fail++; $display("FAIL cond_noneg_s: got %h want 0000003", s); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s; logic ovf, zero; int lat;
    logic [W-1:0] want;
`ifdef TWOS_COMP_SAT_EN
    want = 25'h0FFFFFF;
`else
    want = 25'h1000000;
`endif
    do_op(0, 25'h1000000, 2'b01, 1'b0, s, ovf, zero, lat);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    n_checks++; if (s !== want || zero !== 1'b0) begin n_fail++; $display("FAIL ovf_s: got %h zero=%b want %h 0", s, zero, want); end
    do_op(0, 25'h1000000, 2'b00, 1'b0, s, ovf, zero, lat);
    n_checks++; if (ovf !== 1'b0 || s !== 25'h1000000) begin n_fail++; $display("FAIL pass_most_neg: got %h ovf=%b want 1000000 0", s, ovf); end
  endtask

  task automatic test_abs();
    logic [W-1:0] s; logic ovf, zero; int lat;
    do_op(0, 25'h1FFFFFE, 2'b10, 1'b0, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h0000002) begin n_fail++; $display("FAIL abs_neg_s: got %h want 0000002", s); end
    do_op(0, 25'h0000007, 2'b10, 1'b1, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h0000007) begin n_fail++; $display("FAIL abs_pos_s: got %h want 0000007", s); end
    do_op(0, 25'h0000003, 2'b11, 1'b1, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h1FFFFFD) begin n_fail++; $display("FAIL cond_neg_s: got %h want 1fffffd", s); end
  endtask

  task automatic test_chunk_sizes();
    logic [W-1:0] s; logic ovf, zero; int lat;
    do_op(1, 25'h0155555, 2'b01, 1'b0, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h1EAAAAB) begin n_fail++; $display("FAIL c7_s: got %h want 1eaaaab", s); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL c7_latency: got %0d want 4", lat); end
    do_op(2, 25'h0155555, 2'b01, 1'b0, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h1EAAAAB) begin n_fail++; $display("FAIL c1_s: got %h want 1eaaaab", s); end
    n_checks++; if (lat !== 25) begin n_fail++; $display("FAIL c1_latency: got %0d want 25", lat); end
    cur_sel = 0;
  endtask

  task automatic test_back_to_back();
    int lat;
    cur_sel = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 25'h0000005; in_mode = 2'b01; in_neg = 1'b0; set_iv(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    // Second operand offered continuously from here on.
    in_a = 25'h0000009; in_mode = 2'b00;
    lat = 0;
    while (!ov5 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL bp_latency: got %0d want 5", lat); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (ov5 !== 1'b1 || s5 !== 25'h1FFFFFB || of5 !== 1'b0 || z5 !== 1'b0 || ir5 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b s=%h ovf=%b zero=%b ready=%b want 1 1fffffb 0 0 0",
                 k, ov5, s5, of5, z5, ir5);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (ov5 !== 1'b0 || ir5 !== 1'b1 || s5 !== 25'h1FFFFFB) begin
      n_fail++;
      $display("FAIL bp_handoff: got valid=%b ready=%b s=%h want 0 1 1fffffb", ov5, ir5, s5);
    end
    @(posedge clk); @(negedge clk);
    set_iv(0, 1'b0);
    lat = 0;
    while (!ov5 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    n_checks++; if (lat !== 5 || s5 !== 25'h0000009) begin n_fail++; $display("FAIL bp_second: got lat=%0d s=%h want 5 0000009", lat, s5); end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] s; logic ovf, zero; int lat;
    int seen;
    cur_sel = 0;
    @(negedge clk);
    in_a = 25'h0000001; in_mode = 2'b01; in_neg = 1'b0; set_iv(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_iv(0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (ov5 !== 1'b0 || s5 !== '0 || of5 !== 1'b0 || z5 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got valid=%b s=%h ovf=%b zero=%b want 0 0 0 0", ov5, s5, of5, z5);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ir5 !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", ir5); end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ov5 === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_output: got %0d valid cycles want 0", seen); end
    do_op(0, 25'h0000002, 2'b01, 1'b0, s, ovf, zero, lat);
    n_checks++; if (s !== 25'h1FFFFFE || lat !== 5) begin n_fail++; $display("FAIL midrst_recover: got %h lat=%0d want 1fffffe 5", s, lat); end
  endtask

  initial begin
    test_reset();
    test_negate();
    test_pass();
    test_overflow();
    test_abs();
    test_chunk_sizes();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
